fp_issue_arbiter: RTL and testbench
===================================

FP_ISSUE_ARBITER -- requirements
Module: fp_issue_arbiter

Interface
REQ-001 Parameter ADD_LATENCY, 7, add/sub core latency in cycles; SHALL satisfy MUL_LATENCY < ADD_LATENCY <= 15.
REQ-002 Parameter MUL_LATENCY, 5, multiply core latency in cycles; SHALL be >= 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_op  in  2  opcode: 0 add, 1 sub, 2 mul, 3 illegal.
REQ-007 reqN_dataa, reqN_datab  in  32  IEEE-754 single operands.
REQ-008 reqN_ready  out  1  operation accepted this cycle.
REQ-009 rsp_valid  out  1  result completes this cycle; no backpressure.
REQ-010 rsp_id  out  1  index of the requester owning rsp_result.
REQ-011 rsp_result  out  32  completed result.
REQ-012 addsub_dataa, addsub_datab  out  32  operands to the add/sub core.
REQ-013 add_sub  out  1  core control: 1 add, 0 sub.
REQ-014 addsub_result  in  32  add/sub core output.
REQ-015 mul_dataa, mul_datab  out  32  operands to the multiply core.
REQ-016 mul_result  in  32  multiply core output.
REQ-017 busy  out  1  at least one operation in flight.

Function
REQ-018 Latency L per op: add/sub ADD_LATENCY, mul MUL_LATENCY, illegal 1.
REQ-019 Slot pipeline slot[0..ADD_LATENCY], each {valid, id, kind}; every edge SHALL shift slot[k+1] into slot[k] and clear the top slot.
REQ-020 Requester N SHALL be eligible iff reqN_valid=1 and slot[L] (current cycle, L of reqN_op) is invalid.
REQ-021 At most one issue per cycle; if both eligible, grant the requester not granted most recently (round-robin); after reset, requester 0 has priority.
REQ-022 reqN_ready SHALL be combinational, asserted only in the issue cycle of requester N; the requester SHALL hold valid/op/data stable until ready.
REQ-023 On issue in cycle t, the edge ending t SHALL write slot[L-1] = {1, N, op class}; the round-robin pointer SHALL update on the same edge.
REQ-024 In an issue cycle, the operands of the granted requester SHALL drive the selected core's operand ports combinationally; add_sub = (op==0).
REQ-025 When a core is not issued this cycle, its operand outputs SHALL be 0 and add_sub SHALL be 1.
REQ-026 An illegal op SHALL not drive any core.
REQ-027 rsp_valid = slot[0].valid, rsp_id = slot[0].id, so an op issued in cycle t responds in cycle t+L.
REQ-028 rsp_result SHALL select addsub_result for add/sub, mul_result for mul, and 32'h7FC00000 for illegal; it SHALL be 0 when rsp_valid=0.
REQ-029 Per-requester responses SHALL return in issue order when the latencies are equal; with mixed latencies, order follows completion time.
REQ-030 busy = OR of all slot valid bits.
REQ-031 The slot check SHALL guarantee that two results never complete in the same cycle.

Reset
REQ-032 While reset_n=0 at an edge: all slots invalid, pointer prefers requester 0; outputs rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, reqN_ready=0, core operands 0, add_sub=1.
REQ-033 Reset mid-operation SHALL discard in-flight ops without any response; core pipelines are not flushed, and their outputs are ignored because no slot is valid.

Verification
REQ-034 req0 add 3F800000+40000000 accepted cycle 0 -> rsp_valid cycle 7, id 0, result 40400000; busy cycles 1-7.
REQ-035 Both requesters mul 40000000*40400000 valid cycle 0 -> ready0 cycle 0, ready1 cycle 1; rsp cycles 5 (id 0) and 6 (id 1), both 40C00000.
REQ-036 req0 add accepted cycle 0, req1 mul valid from cycle 2 -> ready1=0 cycle 2, issued cycle 3; rsp id0 cycle 7, id1 cycle 8.
REQ-037 req1 op=3 accepted cycle 0 -> rsp cycle 1, id 1, result 7FC00000; no core operand activity.
REQ-038 Both requesters continuously valid with sub -> grants alternate 0,1,0,1; one rsp per cycle from cycle 7.
REQ-039 reset_n=0 in cycle 3 after add issue in cycle 0 -> no rsp_valid in cycles 4-10; busy=0 from cycle 4.

Source files
------------

// File: rtl/fp_issue_arbiter_if.sv
// Bundle of requester, response and FP-core signals around fp_issue_arbiter.
// The arbiter connects through the slave modport; the requesters and cores connect through the master modport.
interface fp_issue_arbiter_if;
  logic        req0_valid;
  logic [1:0]  req0_op;
  logic [31:0] req0_dataa;
  logic [31:0] req0_datab;
  logic        req0_ready;

  logic        req1_valid;
  logic [1:0]  req1_op;
  logic [31:0] req1_dataa;
  logic [31:0] req1_datab;
  logic        req1_ready;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;

  logic [31:0] addsub_dataa;
  logic [31:0] addsub_datab;
  logic        add_sub;
  logic [31:0] addsub_result;

  logic [31:0] mul_dataa;
  logic [31:0] mul_datab;
  logic [31:0] mul_result;

  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_dataa, req0_datab,
    output req0_ready,
    input  req1_valid, req1_op, req1_dataa, req1_datab,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    output addsub_dataa, addsub_datab, add_sub,
    input  addsub_result,
    output mul_dataa, mul_datab,
    input  mul_result,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_dataa, req0_datab,
    input  req0_ready,
    output req1_valid, req1_op, req1_dataa, req1_datab,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    input  addsub_dataa, addsub_datab, add_sub,
    output addsub_result,
    input  mul_dataa, mul_datab,
    output mul_result,
    input  busy
  );
endinterface

// File: rtl/fp_issue_arbiter.sv
// Two-requester round-robin issue arbiter for fixed-latency add/sub and multiply cores.
// A shift pipeline of completion slots ensures at most one result completes per cycle.
module fp_issue_arbiter #(
  parameter int ADD_LATENCY = 7,
  parameter int MUL_LATENCY = 5
) (
  input logic              clk,
  input logic              reset_n,
  fp_issue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_ADDSUB  = 2'd0,
    KIND_MUL     = 2'd1,
    KIND_ILLEGAL = 2'd2
  } kind_e;

  typedef struct packed {
    logic  valid;
    logic  id;
    kind_e kind;
  } slot_t;

  slot_t slot_q [0:ADD_LATENCY];
  slot_t slot_d [0:ADD_LATENCY];
  logic  last_grant_q;
  logic  last_grant_d;

  logic        add_busy;
  logic        mul_busy;
  logic        ill_busy;
  logic        elig0;
  logic        elig1;
  logic        grant0;
  logic        grant1;
  logic        issue;
  logic        sel_id;
  logic [1:0]  sel_op;
  logic [31:0] sel_dataa;
  logic [31:0] sel_datab;

  // An op of latency L lands in slot[L-1], so slot[L] must be free this cycle.
  function automatic logic op_blocked(input logic [1:0] op, input logic a_busy,
                                      input logic m_busy, input logic i_busy);
    case (op)
      2'd0, 2'd1: op_blocked = a_busy;
      2'd2:       op_blocked = m_busy;
      default:    op_blocked = i_busy;
    endcase
  endfunction

  always_comb begin
    add_busy  = slot_q[ADD_LATENCY].valid;
    mul_busy  = slot_q[MUL_LATENCY].valid;
    ill_busy  = slot_q[1].valid;
    elig0     = reset_n && bus.req0_valid &&
                !op_blocked(bus.req0_op, add_busy, mul_busy, ill_busy);
    elig1     = reset_n && bus.req1_valid &&
                !op_blocked(bus.req1_op, add_busy, mul_busy, ill_busy);
    grant0    = elig0 && (!elig1 || last_grant_q);
    grant1    = elig1 && !grant0;
    issue     = grant0 || grant1;
    sel_id    = grant1;
    sel_op    = grant1 ? bus.req1_op    : bus.req0_op;
    sel_dataa = grant1 ? bus.req1_dataa : bus.req0_dataa;
    sel_datab = grant1 ? bus.req1_datab : bus.req0_datab;
  end

  always_comb begin
    for (int k = 0; k < ADD_LATENCY; k++) begin
      slot_d[k] = slot_q[k + 1];
    end
    slot_d[ADD_LATENCY] = '0;
    last_grant_d        = last_grant_q;
    if (issue) begin
      last_grant_d = sel_id;
      case (sel_op)
        2'd0, 2'd1: begin
          slot_d[ADD_LATENCY - 1].valid = 1'b1;
          slot_d[ADD_LATENCY - 1].id    = sel_id;
          slot_d[ADD_LATENCY - 1].kind  = KIND_ADDSUB;
        end
        2'd2: begin
          slot_d[MUL_LATENCY - 1].valid = 1'b1;
          slot_d[MUL_LATENCY - 1].id    = sel_id;
          slot_d[MUL_LATENCY - 1].kind  = KIND_MUL;
        end
        default: begin
          slot_d[0].valid = 1'b1;
          slot_d[0].id    = sel_id;
          slot_d[0].kind  = KIND_ILLEGAL;
        end
      endcase
    end
  end

  // Reset leaves requester 0 preferred by marking requester 1 as last granted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k <= ADD_LATENCY; k++) begin
        slot_q[k] <= '0;
      end
      last_grant_q <= 1'b1;
    end else begin
      for (int k = 0; k <= ADD_LATENCY; k++) begin
        slot_q[k] <= slot_d[k];
      end
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    bus.req0_ready   = grant0;
    bus.req1_ready   = grant1;
    bus.addsub_dataa = '0;
    bus.addsub_datab = '0;
    bus.add_sub      = 1'b1;
    bus.mul_dataa    = '0;
    bus.mul_datab    = '0;
    if (issue && (sel_op == 2'd0 || sel_op == 2'd1)) begin
      bus.addsub_dataa = sel_dataa;
      bus.addsub_datab = sel_datab;
      bus.add_sub      = (sel_op == 2'd0);
    end
    if (issue && sel_op == 2'd2) begin
      bus.mul_dataa = sel_dataa;
      bus.mul_datab = sel_datab;
    end
  end

  always_comb begin
    bus.rsp_valid  = slot_q[0].valid;
    bus.rsp_id     = slot_q[0].id;
    bus.rsp_result = '0;
    if (slot_q[0].valid) begin
      case (slot_q[0].kind)
        KIND_ADDSUB: bus.rsp_result = bus.addsub_result;
        KIND_MUL:    bus.rsp_result = bus.mul_result;
        default:     bus.rsp_result = 32'h7FC0_0000;
      endcase
    end
    bus.busy = 1'b0;
    for (int k = 0; k <= ADD_LATENCY; k++) begin
      bus.busy = bus.busy | slot_q[k].valid;
    end
  end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Directed bench for fp_issue_arbiter with behavioural fixed-latency cores.
// Cores return looked-up results for the handful of operand pairs used here.
module tb_fp_issue_arbiter;
  localparam int ADD_LAT = 7;
  localparam int MUL_LAT = 5;

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FIVE  = 32'h40A0_0000;
  localparam logic [31:0] SIX   = 32'h40C0_0000;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  fp_issue_arbiter_if bus();

  fp_issue_arbiter #(.ADD_LATENCY(ADD_LAT), .MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] add_model(input logic is_add, input logic [31:0] a,
                                            input logic [31:0] b);
    if (is_add && a == ONE && b == TWO)        return THREE;
    else if (!is_add && a == THREE && b == ONE) return TWO;
    else if (!is_add && a == FIVE && b == TWO)  return THREE;
    else                                        return JUNK;
  endfunction

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == TWO && b == THREE) return SIX;
    else                        return JUNK;
  endfunction

  logic [31:0] add_pipe [0:ADD_LAT-1];
  logic [31:0] mul_pipe [0:MUL_LAT-1];

  // Cores are free-running pipelines with no reset, like the real IP.
  always @(posedge clk) begin
    add_pipe[0] <= add_model(bus.add_sub, bus.addsub_dataa, bus.addsub_datab);
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
    mul_pipe[0] <= mul_model(bus.mul_dataa, bus.mul_datab);
    for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end

  assign bus.addsub_result = add_pipe[ADD_LAT-1];
  assign bus.mul_result    = mul_pipe[MUL_LAT-1];

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int n, input logic v, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_dataa = a; bus.req0_datab = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_dataa = a; bus.req1_datab = b;
    end
  endtask

  task automatic idle_inputs();
    apply_stimulus(0, 1'b0, 2'd0, 32'h0, 32'h0);
    apply_stimulus(1, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  // Leaves the bench at the start of cycle 0, first cycle out of reset.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // Reset state, with a request held to confirm ready stays low in reset.
    tick();
    apply_stimulus(0, 1'b1, 2'd0, ONE, TWO);
    tick();
    sample();
    check_bit ("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit ("rst_rsp_id", bus.rsp_id, 1'b0);
    check_word("rst_rsp_result", bus.rsp_result, 32'h0);
    check_bit ("rst_busy", bus.busy, 1'b0);
    check_bit ("rst_ready0", bus.req0_ready, 1'b0);
    check_word("rst_addsub_dataa", bus.addsub_dataa, 32'h0);
    check_bit ("rst_add_sub", bus.add_sub, 1'b1);

    // Single add from requester 0.
    do_reset();
    apply_stimulus(0, 1'b1, 2'd0, ONE, TWO);
    sample();
    check_bit ("add_ready0", bus.req0_ready, 1'b1);
    check_bit ("add_ready1", bus.req1_ready, 1'b0);
    check_word("add_dataa", bus.addsub_dataa, ONE);
    check_word("add_datab", bus.addsub_datab, TWO);
    check_bit ("add_add_sub", bus.add_sub, 1'b1);
    check_word("add_mul_dataa", bus.mul_dataa, 32'h0);
    check_bit ("add_busy_c0", bus.busy, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      idle_inputs();
      sample();
      check_bit ($sformatf("add_rsp_valid_c%0d", c), bus.rsp_valid, c == 7);
      check_bit ($sformatf("add_busy_c%0d", c), bus.busy, c <= 7);
      check_bit ($sformatf("add_rsp_id_c%0d", c), bus.rsp_id, 1'b0);
      check_word($sformatf("add_rsp_result_c%0d", c), bus.rsp_result, (c == 7) ? THREE : 32'h0);
    end

    // Both requesters multiply at once.
    do_reset();
    apply_stimulus(0, 1'b1, 2'd2, TWO, THREE);
    apply_stimulus(1, 1'b1, 2'd2, TWO, THREE);
    sample();
    check_bit ("mul_ready0_c0", bus.req0_ready, 1'b1);
    check_bit ("mul_ready1_c0", bus.req1_ready, 1'b0);
    check_word("mul_dataa_c0", bus.mul_dataa, TWO);
    check_word("mul_datab_c0", bus.mul_datab, THREE);
    check_word("mul_addsub_dataa_c0", bus.addsub_dataa, 32'h0);
    tick();
    apply_stimulus(0, 1'b0, 2'd0, 32'h0, 32'h0);
    sample();
    check_bit ("mul_ready0_c1", bus.req0_ready, 1'b0);
    check_bit ("mul_ready1_c1", bus.req1_ready, 1'b1);
    check_word("mul_dataa_c1", bus.mul_dataa, TWO);
    for (int c = 2; c <= 7; c++) begin
      tick();
      idle_inputs();
      sample();
      check_bit ($sformatf("mul_rsp_valid_c%0d", c), bus.rsp_valid, c == 5 || c == 6);
      check_bit ($sformatf("mul_rsp_id_c%0d", c), bus.rsp_id, c == 6);
      check_word($sformatf("mul_rsp_result_c%0d", c), bus.rsp_result,
                 (c == 5 || c == 6) ? SIX : 32'h0);
    end

    // Add in flight blocks a multiply that would complete in the same cycle.
    do_reset();
    apply_stimulus(0, 1'b1, 2'd0, ONE, TWO);
    sample();
    check_bit("mix_ready0_c0", bus.req0_ready, 1'b1);
    tick();
    idle_inputs();
    tick();
    apply_stimulus(1, 1'b1, 2'd2, TWO, THREE);
    sample();
    check_bit ("mix_ready1_c2", bus.req1_ready, 1'b0);
    check_word("mix_mul_dataa_c2", bus.mul_dataa, 32'h0);
    tick();
    sample();
    check_bit ("mix_ready1_c3", bus.req1_ready, 1'b1);
    check_word("mix_mul_dataa_c3", bus.mul_dataa, TWO);
    for (int c = 4; c <= 9; c++) begin
      tick();
      idle_inputs();
      sample();
      check_bit ($sformatf("mix_rsp_valid_c%0d", c), bus.rsp_valid, c == 7 || c == 8);
      check_bit ($sformatf("mix_rsp_id_c%0d", c), bus.rsp_id, c == 8);
      check_word($sformatf("mix_rsp_result_c%0d", c), bus.rsp_result,
                 (c == 7) ? THREE : ((c == 8) ? SIX : 32'h0));
    end

    // Illegal opcode from requester 1.
    do_reset();
    apply_stimulus(1, 1'b1, 2'd3, ONE, TWO);
    sample();
    check_bit ("ill_ready1", bus.req1_ready, 1'b1);
    check_word("ill_addsub_dataa", bus.addsub_dataa, 32'h0);
    check_word("ill_addsub_datab", bus.addsub_datab, 32'h0);
    check_word("ill_mul_dataa", bus.mul_dataa, 32'h0);
    check_word("ill_mul_datab", bus.mul_datab, 32'h0);
    check_bit ("ill_add_sub", bus.add_sub, 1'b1);
    tick();
    idle_inputs();
    sample();
    check_bit ("ill_rsp_valid_c1", bus.rsp_valid, 1'b1);
    check_bit ("ill_rsp_id_c1", bus.rsp_id, 1'b1);
    check_word("ill_rsp_result_c1", bus.rsp_result, QNAN);
    tick();
    sample();
    check_bit ("ill_rsp_valid_c2", bus.rsp_valid, 1'b0);

    // Continuous subtracts from both requesters alternate grants.
    do_reset();
    apply_stimulus(0, 1'b1, 2'd1, THREE, ONE);
    apply_stimulus(1, 1'b1, 2'd1, FIVE, TWO);
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      sample();
      check_bit ($sformatf("rr_ready0_c%0d", c), bus.req0_ready, c % 2 == 0);
      check_bit ($sformatf("rr_ready1_c%0d", c), bus.req1_ready, c % 2 == 1);
      check_bit ($sformatf("rr_add_sub_c%0d", c), bus.add_sub, 1'b0);
      check_word($sformatf("rr_dataa_c%0d", c), bus.addsub_dataa, (c % 2 == 0) ? THREE : FIVE);
      check_bit ($sformatf("rr_rsp_valid_c%0d", c), bus.rsp_valid, c >= 7);
      check_bit ($sformatf("rr_rsp_id_c%0d", c), bus.rsp_id, c >= 7 && (c - 7) % 2 == 1);
      check_word($sformatf("rr_rsp_result_c%0d", c), bus.rsp_result,
                 (c < 7) ? 32'h0 : (((c - 7) % 2 == 0) ? TWO : THREE));
    end

    // Reset mid-flight discards the pending add.
    do_reset();
    apply_stimulus(0, 1'b1, 2'd0, ONE, TWO);
    sample();
    check_bit("flush_ready0_c0", bus.req0_ready, 1'b1);
    tick();
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b0;
    sample();
    check_bit("flush_busy_c3", bus.busy, 1'b1);
    for (int c = 4; c <= 10; c++) begin
      tick();
      if (c == 4) reset_n = 1'b1;
      sample();
      check_bit($sformatf("flush_rsp_valid_c%0d", c), bus.rsp_valid, 1'b0);
      check_bit($sformatf("flush_busy_c%0d", c), bus.busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
